// File: rtl/follower_pkg.sv
// Shared types and constants for the station-ID barcode receiver.
// Holds the receiver FSM state enum, frame width, synchronizer depth and the
// reserved-bit mask used to validate a decoded station ID.
package follower_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    HOLD,
    WAIT_FALL,
    SAMPLE,
    CHECK
  } bc_state_t;

  localparam int         BC_BITS     = 8;
  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] ID_MASK     = 8'hC0;

  // A station ID is legal only when its two reserved MSBs are clear.
  function automatic logic id_ok(input logic [7:0] v);
    return (v & ID_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/bc_sync.sv
// Synchronizer and falling-edge detector for the raw barcode input.
// Ports: clk, rst (sync, active-high); BC raw async in; BC_s synchronized
//        level; fall is high for one cycle after BC_s goes 1 -> 0.
module bc_sync
  import follower_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic BC,
  output logic BC_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // All flops reset high so a line idling high never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], BC};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign BC_s = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~BC_s;

endmodule

// File: rtl/barcode_rx.sv
// Self-clocking serial barcode receiver producing an 8-bit station ID.
// Ports: clk, rst (sync, active-high); BC raw stream; clr_ID_vld clears the
//        sticky ID_vld; ID/ID_vld result; BC_err 1-cycle error pulse; busy.
// Optional: define BC_TIMEOUT_EN to add a missing-edge watchdog in WAIT_FALL.
module barcode_rx
  import follower_pkg::*;
#(
  parameter int CNT_W   = 22,
  parameter int MIN_PER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld,
  output logic       BC_err,
  output logic       busy
);

  bc_state_t                state_q, state_n;
  logic                     BC_s, fall;
  logic [CNT_W-1:0]         per_cnt, period, smp_cnt;
  logic [2:0]               bit_cnt;
  logic [BC_BITS-1:0]       sh_reg;
  logic                     per_sat, err_set, load_id;

  bc_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .BC   (BC),
    .BC_s (BC_s),
    .fall (fall)
  );

  assign per_sat = &per_cnt;
  assign busy    = (state_q != IDLE);

`ifdef BC_TIMEOUT_EN
  // Cycles since the last falling edge; a healthy frame produces one fall
  // per bit period, so 4 periods of silence means the frame was truncated.
  logic [CNT_W+1:0] wd_cnt;
  logic             wd_expired;

  always_ff @(posedge clk) begin
    if (rst || fall) wd_cnt <= '0;
    else if (!(&wd_cnt)) wd_cnt <= wd_cnt + (CNT_W+2)'(1);
  end

  assign wd_expired = (wd_cnt >= {period, 2'b00});
`endif

  always_comb begin
    state_n = state_q;
    err_set = 1'b0;
    load_id = 1'b0;
    case (state_q)
      IDLE:      if (fall) state_n = START;
      START: begin
        if (BC_s) state_n = (per_cnt < CNT_W'(MIN_PER)) ? IDLE : WAIT_FALL;
        else if (per_sat) begin
          err_set = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD:      if (BC_s) state_n = IDLE;
      WAIT_FALL: begin
        if (fall) state_n = SAMPLE;
`ifdef BC_TIMEOUT_EN
        else if (wd_expired) begin
          err_set = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      SAMPLE: begin
        if (smp_cnt == '0)
          state_n = (bit_cnt == 3'(BC_BITS-1)) ? CHECK : WAIT_FALL;
      end
      CHECK: begin
        state_n = IDLE;
        if (id_ok(sh_reg)) load_id = 1'b1;
        else               err_set = 1'b1;
      end
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      per_cnt <= '0;
      period  <= '0;
      smp_cnt <= '0;
      bit_cnt <= '0;
      sh_reg  <= '0;
      ID      <= 8'h00;
      ID_vld  <= 1'b0;
      BC_err  <= 1'b0;
    end else begin
      state_q <= state_n;
      BC_err  <= err_set;
      if (load_id) ID <= sh_reg;
      // A new ID in the same cycle as a clear leaves the flag set.
      if (load_id)         ID_vld <= 1'b1;
      else if (clr_ID_vld) ID_vld <= 1'b0;

      case (state_q)
        IDLE:      if (fall) per_cnt <= '0;
        START: begin
          if (!BC_s && !per_sat) per_cnt <= per_cnt + CNT_W'(1);
          if (BC_s) begin
            period  <= per_cnt;
            bit_cnt <= '0;
          end
        end
        // Sample half a period after each bit's falling edge.
        WAIT_FALL: if (fall) smp_cnt <= period >> 1;
        SAMPLE: begin
          if (smp_cnt == '0) begin
            sh_reg  <= {sh_reg[BC_BITS-2:0], BC_s};
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            smp_cnt <= smp_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barcode_rx.sv
module tb_barcode_rx;

  logic       clk = 1'b0;
  logic       rst, BC, clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld, BC_err, busy;

  barcode_rx dut (
    .clk        (clk),
    .rst        (rst),
    .BC         (BC),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .ID_vld     (ID_vld),
    .BC_err     (BC_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Behavioural model: what the consumer-visible outputs must be once the
  // line has gone quiet after a frame.
  logic [7:0] exp_id   = 8'h00;
  logic       exp_vld  = 1'b0;
  int         exp_errs = 0;
  logic       settled  = 1'b0;

  // Observations
  int   dut_errs = 0, busy_hi = 0;
  int   vld_rise_cyc = -1, err_cyc = -1, last_fall_cyc = 0;
  int   clr_cd = -1;
  logic prev_vld = 1'b0, prev_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame outcome from the decoding rules: legal IDs have bits 7:6 clear.
  task automatic apply_frame(input logic [7:0] b);
    if (b[7:6] == 2'b00) begin
      exp_id  = b;
      exp_vld = 1'b1;
    end else begin
      exp_errs++;
    end
  endtask

  always @(negedge clk) begin
    if (settled && !rst) begin
      chk("ID", {24'h0, ID}, {24'h0, exp_id});
      chk("ID_vld", {31'h0, ID_vld}, {31'h0, exp_vld});
      chk("busy_idle", {31'h0, busy}, 32'h0);
    end
    if (BC_err) begin
      dut_errs++;
      err_cyc = cyc;
      chk("err_pulse_width", {31'h0, prev_err}, 32'h0);
    end
    if (ID_vld && !prev_vld) vld_rise_cyc = cyc;
    if (busy) busy_hi++;
    prev_err = BC_err;
    prev_vld = ID_vld;
  end

  task automatic step(input logic v);
    clr_ID_vld = (clr_cd == 0);
    if (clr_cd >= 0) clr_cd--;
    BC = v;
    @(negedge clk);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  // One frame: start bit low p cycles, high p; each bit falls, stays low
  // p/4 for a 1 or 3p/4 for a 0, and is p cycles long, MSB first.
  task automatic send_byte(input logic [7:0] b, input int p, input int rst_bit,
                           input int stop_bit, input bit clr_on_load);
    int lo;
    settled = 1'b0;
    last_fall_cyc = cyc;
    hold(1'b0, p);
    hold(1'b1, p);
    for (int i = 7; i >= 0; i--) begin
      if (7 - i == stop_bit) begin
        hold(1'b1, 4 * p + 64);
        return;
      end
      lo = b[i] ? p / 4 : 3 * p / 4;
      // Clear lands on the edge where ID_vld is loaded (p=64 frames).
      if (i == 0 && clr_on_load) clr_cd = 35;
      last_fall_cyc = cyc;
      hold(1'b0, lo);
      if (i == rst_bit) begin
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        hold(1'b1, 2 * p);
        return;
      end
      hold(1'b1, p - lo);
    end
    hold(1'b1, 8);
  endtask

  task automatic settle();
    hold(1'b1, 4);
    settled = 1'b1;
    hold(1'b1, 8);
    chk("err_count", dut_errs, exp_errs);
  endtask

  task automatic clr_pulse();
    settled = 1'b0;
    clr_cd  = 0;
    step(1'b1);
    exp_vld = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b1;
    BC = 1'b1;
    clr_ID_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ID", {24'h0, ID}, 32'h00);
    chk("rst_ID_vld", {31'h0, ID_vld}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_BC_err", {31'h0, BC_err}, 32'h0);
    rst = 1'b0;
    settle();

    // Long period frame; also pins first-frame latency.
    vld_rise_cyc = -1;
    send_byte(8'h01, 4096, -1, -1, 1'b0);
    apply_frame(8'h01);
    settle();
    chk("lat_p4096", vld_rise_cyc - last_fall_cyc, 2052);
    chk("id_01", {24'h0, ID}, 32'h01);

    send_byte(8'h3F, 64, -1, -1, 1'b0);
    apply_frame(8'h3F);
    settle();
    send_byte(8'h15, 64, -1, -1, 1'b0);
    apply_frame(8'h15);
    settle();
    chk("id_15", {24'h0, ID}, 32'h15);
    chk("vld_after_15", {31'h0, ID_vld}, 32'h1);

    clr_pulse();
    chk("id_hold_after_clr", {24'h0, ID}, 32'h15);

    send_byte(8'hC5, 64, -1, -1, 1'b0);
    apply_frame(8'hC5);
    settle();
    chk("c5_err_total", dut_errs, 1);
    chk("c5_id_kept", {24'h0, ID}, 32'h15);

    // Sub-MIN_PER glitch.
    settled = 1'b0;
    busy_hi = 0;
    hold(1'b0, 2);
    hold(1'b1, 10);
    settle();
    chk("glitch_busy_le3", {31'h0, (busy_hi <= 3)}, 32'h1);

    // Reset mid-frame abandons it and restores reset values.
    send_byte(8'h2A, 64, 4, -1, 1'b0);
    exp_id  = 8'h00;
    exp_vld = 1'b0;
    settle();

    vld_rise_cyc = -1;
    send_byte(8'h07, 64, -1, -1, 1'b1);
    apply_frame(8'h07);
    settle();
    chk("lat_p64", vld_rise_cyc - last_fall_cyc, 36);
    chk("id_07", {24'h0, ID}, 32'h07);
    chk("vld_set_beats_clr", {31'h0, ID_vld}, 32'h1);

`ifdef BC_TIMEOUT_EN
    clr_pulse();
    err_cyc = -1;
    send_byte(8'h55, 4096, -1, 3, 1'b0);
    exp_errs++;
    settle();
    chk("timeout_delay_ok",
        {31'h0, ((err_cyc - last_fall_cyc) >= 16376) && ((err_cyc - last_fall_cyc) <= 16392)},
        32'h1);
    chk("timeout_vld", {31'h0, ID_vld}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
